seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode/cathode 7-segment digits with decimal points. It accepts a packed hex value, holds it in a load-strobed shadow register and refreshes the visible value only at frame boundaries, so a frame never tears. It decodes each nibble to a segment glyph, scans the digits with a programmable slot length and anti-ghosting dead time, and optionally suppresses leading zeros. It sits between the counter/timer datapath and the board display pins.

## Interface
- DIGITS, 4: number of digits; legal range 1..8.
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- DEAD, 2: cycles at the start of each slot with all digits and segments off; must be < CLK_DIV.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its bit is 0.
- DIG_ACTIVE_LOW, 1: 1 means a digit is enabled when its bit is 0.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  hex digits; value[3:0] is digit 0 (rightmost).
- dp  in  DIGITS  decimal point per digit; dp[i] is digit i.
- load  in  1  captures value and dp into the shadow register on this edge.
- lz_blank  in  1  leading-zero suppression enable; sampled live.
- seg  out  8  bit7..bit0 = a,b,c,d,e,f,g,dp.
- dig  out  DIGITS  digit enables; dig[i] drives digit i.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Shadow register (value, dp) is loaded when load=1. The display register copies the shadow at every frame start.
- Glyphs (active-low byte, dp off): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 B:C1 C:63 D:85 E:61 F:71. dp[i]=1 clears bit0.
- SEG_ACTIVE_LOW=0 inverts all of seg. DIG_ACTIVE_LOW=0 inverts all of dig.
- "Off" means all segments unlit and all digits disabled.
- Leading-zero suppression: when lz_blank=1 and nibbles i..DIGITS-1 of the display register are all 0 with i>0, digit i shows no a–g segments.
  - The dp of a suppressed digit still follows dp[i].
  - Digit 0 is never suppressed.
- Internal state:
  - Prescaler phase counts 0..CLK_DIV-1.
  - Digit index advances when phase wraps and itself wraps DIGITS-1 → 0.
  - Both counters are free-running after reset.

## Timing
- Reset (rst=1 at an edge):
  - phase=0, index=0, shadow=0, display register=0.
  - seg=off, dig=off, frame_tick=0.
  - load is ignored while rst=1.
- Edge numbering: edge n is the n-th rising edge with rst=0, n≥1. Let m=n-1.
  - phase=m mod CLK_DIV.
  - slot=m div CLK_DIV.
  - digit k=slot mod DIGITS.
- Frame start: edge where phase=0 and k=0, including edge 1. The display register takes the shadow value held before that edge.
- Outputs are registered and take these values immediately after edge n:
  - phase<DEAD: seg=off, dig=off.
  - otherwise: dig enables only digit k, and seg=glyph of display nibble k (suppression applied).
- frame_tick=1 after edge n iff phase=CLK_DIV-1 and k=DIGITS-1; otherwise 0.
- Simultaneous events:
  - load on a frame-start edge: the shadow takes the new data, but the frame just starting shows the old shadow. The new data appears one frame later.
  - Repeated loads within a frame: the last one wins.
- rst asserted mid-frame returns every output to the reset values on that edge. Scanning restarts at digit 0.
- DIGITS=1: index stays 0, and frame_tick pulses every CLK_DIV cycles.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=4, DEAD=1, active-low polarity.
- Reset: hold rst for 3 edges with load=1 and value=16'hFFFF.
  - Required after each edge: seg=8'hFF, dig=4'hF, frame_tick=0.
  - After release, frame 0 shows digits 0,0,0,0 (seg=8'h03).
- Scan order and dead time: load value=16'h1234, dp=0 at edge 1.
  - Frame 0 (edges 1–16): all digits 8'h03.
  - Edge 17: seg=FF, dig=F.
  - Edges 18–20: dig=4'b1110, seg=8'h99.
  - Edges 22–24: dig=4'b1101, seg=8'h0D.
  - Digit 2 slot: 8'h25. Digit 3 slot: 8'h9F.
  - frame_tick high only after edges 16, 32, 48, …
- Decimal point and hex glyphs: value=16'hAbCd with dp=4'b0100.
  - Digit 0: 8'h85. Digit 1: 8'h63.
  - Digit 2: 8'hC0 (dp lit). Digit 3: 8'h11.
- Leading-zero suppression: value=16'h0007, lz_blank=1, dp=4'b1000.
  - Digit 0: 8'h1F. Digits 1 and 2: 8'hFF.
  - Digit 3: 8'hFE (dp only). dig still scans every digit.
- Tear-free load: load 16'h1111 at edge 17 (frame start), then 16'h2222 at edge 20.
  - Frame 1 shows 0000. Frame 2 shows 2222. 1111 is never displayed.
- Mid-frame reset: rst at edge 22.
  - Outputs are off after that edge.
  - Scanning restarts at digit 0, and the display value returns to 0000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with tear-free shadow load, dead time and leading-zero blanking
//   clk, rst        : clock, synchronous active-high reset
//   value, dp, load : packed hex digits and decimal points, captured into the shadow on load
//   lz_blank        : live leading-zero suppression enable
//   seg, dig        : registered segment byte (a..g,dp) and digit enables
//   frame_tick      : one-cycle pulse on the last cycle of each frame
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD           = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_tick
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    localparam logic [7:0] SEG_INV = SEG_ACTIVE_LOW != 0 ? 8'h00 : 8'hFF;
    localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [DIGITS-1:0] DIG_INV = DIG_ACTIVE_LOW != 0 ? '0 : '1;
    localparam logic [7:0] GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic [PW-1:0]         phase_q, phase_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic [7:0]            seg_q, seg_d, seg_raw;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  tick_q, tick_d;
    logic                  phase_wrap, frame_start, live, sup;
    logic [3:0]            nib;

    always_comb begin
        phase_wrap   = phase_q == PW'(CLK_DIV - 1);
        frame_start  = phase_q == '0 && idx_q == '0;
        phase_d      = phase_wrap ? '0 : phase_q + 1'b1;
        idx_d        = !phase_wrap ? idx_q : (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1);
        shadow_val_d = load ? value : shadow_val_q;
        shadow_dp_d  = load ? dp : shadow_dp_q;
        // The frame being started shows the shadow as it stood before this edge
        disp_val_d   = frame_start ? shadow_val_q : disp_val_q;
        disp_dp_d    = frame_start ? shadow_dp_q : disp_dp_q;
        nib          = disp_val_d[{idx_q, 2'b00} +: 4];
        // Digit k is a leading zero when every nibble from k upward is zero
        sup          = lz_blank && idx_q != '0 && (disp_val_d >> {idx_q, 2'b00}) == '0;
        seg_raw      = {GLYPH[nib][7:1] | {7{sup}}, ~disp_dp_d[idx_q]};
        live         = phase_q >= PW'(DEAD);
        seg_d        = live ? seg_raw ^ SEG_INV : SEG_OFF;
        dig_d        = live ? ~(DIGITS'(1) << idx_q) ^ DIG_INV : DIG_OFF;
        tick_d       = phase_wrap && idx_q == IW'(DIGITS - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            tick_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            tick_q       <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, dead time, glyphs, blanking, tear-free load and reset
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_tick;
    int          vectors = 0;
    int          errs = 0;
    logic [7:0]  gly [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    seg7_scan_driver #(
        .DIGITS(4), .CLK_DIV(4), .DEAD(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .lz_blank(lz_blank),
        .seg(seg), .dig(dig), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] es, input logic [3:0] ed, input logic et);
        vectors++;
        assert (seg === es) else begin errs++; $error("FAIL %s seg got %h exp %h", tag, seg, es); end
        vectors++;
        assert (dig === ed) else begin errs++; $error("FAIL %s dig got %h exp %h", tag, dig, ed); end
        vectors++;
        assert (frame_tick === et) else begin errs++; $error("FAIL %s tick got %b exp %b", tag, frame_tick, et); end
    endtask

    // Steps one whole frame; drops load after its first edge and optionally loads mid_val before its fourth edge
    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] d, input logic lz,
                               input logic do_mid, input logic [15:0] mid_val);
        logic [7:0] es;
        logic [3:0] ed;
        logic [3:0] nib;
        for (int j = 0; j < 16; j++) begin
            if (j == 1) load = 1'b0;
            if (j == 3 && do_mid) begin value = mid_val; load = 1'b1; end
            if (j == 4 && do_mid) load = 1'b0;
            step();
            if (j % 4 == 0) begin
                es = 8'hFF;
                ed = 4'hF;
            end else begin
                nib = v[4*(j/4) +: 4];
                es = gly[nib];
                if (lz && j / 4 > 0 && (v >> (4 * (j / 4))) == 16'h0) es = es | 8'hFE;
                if (d[j/4]) es = es & 8'hFE;
                ed = ~(4'b0001 << (j / 4));
            end
            chk($sformatf("%s e%0d", tag, j), es, ed, j == 15);
        end
    endtask

    initial begin
        load = 1'b1;
        value = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset%0d", i), 8'hFF, 4'hF, 1'b0);
        end
        rst = 1'b0;
        value = 16'h1234;
        dp = 4'h0;
        check_frame("f0", 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0);
        value = 16'hABCD; dp = 4'b0100; load = 1'b1;
        check_frame("f1", 16'h1234, 4'h0, 1'b0, 1'b0, 16'h0);
        value = 16'h0007; dp = 4'b1000; load = 1'b1; lz_blank = 1'b1;
        check_frame("f2", 16'hABCD, 4'b0100, 1'b1, 1'b0, 16'h0);
        value = 16'h1111; dp = 4'h0; load = 1'b1;
        check_frame("f3", 16'h0007, 4'b1000, 1'b1, 1'b1, 16'h2222);
        lz_blank = 1'b0;
        check_frame("f4", 16'h2222, 4'h0, 1'b0, 1'b0, 16'h0);
        step();
        step();
        chk("f5 d0", 8'h25, 4'b1110, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst", 8'hFF, 4'hF, 1'b0);
        rst = 1'b0;
        check_frame("f6", 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
